// File: rtl/uart_arb_pkg.sv
// Shared types, defaults and helpers for the UART transmit arbiter.
package uart_arb_pkg;

  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_TIMEOUT_CYC = 200000;
  localparam int MAX_REQ         = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // One-hot vector with bit id set; callers truncate to their requester count.
  function automatic logic [MAX_REQ-1:0] onehot(input int unsigned id);
    return MAX_REQ'(1) << id;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin pick: first set request bit after last_id, wrapping modulo NUM_REQ.
module rr_priority_pick
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_id,
  output logic               valid,
  output logic [ID_W-1:0]    win_id
);

  int idx;

  // Scan from the farthest offset down so the nearest requester after last_id wins.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    valid  = 1'b0;
    win_id = '0;
    idx    = 0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = (int'(last_id) + i) % NUM_REQ;
      if (req[idx]) begin
        valid  = 1'b1;
        win_id = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ requesters with round-robin grant,
// a one-cycle start pulse, done-edge acknowledge and a watchdog abort.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      err,
  output logic                      busy,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_done
);

  localparam int ID_W    = $clog2(NUM_REQ);
  localparam int TIMER_W = $clog2(TIMEOUT_CYC);

  state_t             state;
  logic [ID_W-1:0]    last_id;
  logic [ID_W-1:0]    id_q;
  logic [TIMER_W-1:0] timer;
  logic               done_q;
  logic               pick_valid;
  logic [ID_W-1:0]    win_id;
  logic               done_rise;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req     (req),
    .last_id (last_id),
    .valid   (pick_valid),
    .win_id  (win_id)
  );

  // A fresh 0->1 of tx_done; a level already high on entry to WAIT does not count.
  assign done_rise = tx_done & ~done_q;

  // Arbitration FSM with watchdog timer and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      last_id  <= ID_W'(NUM_REQ - 1);
      id_q     <= '0;
      timer    <= '0;
      done_q   <= 1'b0;
      gnt      <= '0;
      ack      <= '0;
      err      <= 1'b0;
      busy     <= 1'b0;
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      done_q <= tx_done;
      ack    <= '0;
      err    <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            gnt      <= NUM_REQ'(onehot(32'(win_id)));
            id_q     <= win_id;
            tx_data  <= req_data[int'(win_id)*DATA_W +: DATA_W];
            tx_start <= 1'b1;
            busy     <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          tx_start <= 1'b0;
          timer    <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (done_rise) begin
            ack     <= NUM_REQ'(onehot(32'(id_q)));
            gnt     <= '0;
            busy    <= 1'b0;
            last_id <= id_q;
            state   <= IDLE;
          end else if (timer == TIMER_W'(TIMEOUT_CYC - 1)) begin
            err     <= 1'b1;
            gnt     <= '0;
            busy    <= 1'b0;
            last_id <= id_q;
            state   <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a behavioural UART frame model answers tx_start
// with tx_done and records the byte; a scoreboard queue holds the expected
// (requester, byte) order and is checked at each grant and each ack.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 50;
  localparam int FRAME   = 12;
  localparam int BUDGET  = 400;

  typedef struct {
    int unsigned      id;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        ack;
  logic                      err;
  logic                      busy;
  logic                      tx_start;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_done = 1'b0;

  int n_cmp = 0;
  int n_mis = 0;

  exp_t              exp_q[$];
  logic [DATA_W-1:0] rx_q[$];
  logic              uart_en = 1'b1;
  logic              err_allowed = 1'b0;
  logic              start_prev = 1'b0;
  int                frame_cnt = 0;
  int                done_hold = 0;
  logic [DATA_W-1:0] frame_byte = '0;
  exp_t              mon_e;
  logic [DATA_W-1:0] mon_rx;

  uart_tx_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (TIMEOUT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .ack      (ack),
    .err      (err),
    .busy     (busy),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_done  (tx_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // UART frame model plus scoreboard monitor, both sampled on the falling edge.
  always @(negedge clk) begin
    if (done_hold > 0) begin
      done_hold--;
      if (done_hold == 0) tx_done = 1'b0;
    end
    if (frame_cnt > 0) begin
      frame_cnt--;
      if (frame_cnt == 0) begin
        tx_done = 1'b1;
        rx_q.push_back(frame_byte);
        done_hold = 2;
      end
    end
    if (tx_start && uart_en && frame_cnt == 0) begin
      frame_byte = tx_data;
      frame_cnt  = FRAME;
    end

    if (start_prev) check("start_one_cycle", 32'(tx_start), 32'd0);
    if (tx_start && !start_prev) begin
      check("start_busy", 32'(busy), 32'd1);
      if (exp_q.size() > 0) begin
        check("grant_onehot", 32'(gnt), 32'(1) << exp_q[0].id);
        check("grant_data", 32'(tx_data), 32'(exp_q[0].data));
      end
    end
    start_prev = tx_start;

    if (|ack) begin
      check("ack_busy_low", 32'(busy), 32'd0);
      check("ack_gnt_low", 32'(gnt), 32'd0);
      if (exp_q.size() == 0) begin
        check("ack_unexpected", 32'(ack), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("ack_id", 32'(ack), 32'(1) << mon_e.id);
        check("rx_available", 32'(rx_q.size() > 0), 32'd1);
        if (rx_q.size() > 0) begin
          mon_rx = rx_q.pop_front();
          check("rx_data", 32'(mon_rx), 32'(mon_e.data));
        end
      end
    end
    if (err && !err_allowed) check("err_spurious", 32'(err), 32'd0);
  end

  task automatic set_data(input int i, input logic [DATA_W-1:0] d);
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic push_exp(input int unsigned id, input logic [DATA_W-1:0] d);
    exp_t e;
    e.id   = id;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", 32'({gnt, ack, err, busy, tx_start, tx_data}), 32'd0);
    reset = 1'b1;
  endtask

  task automatic wait_ack(input string tag, output logic [NUM_REQ-1:0] a);
    int n;
    n = 0;
    a = '0;
    do begin
      @(negedge clk);
      n++;
    end while (!(|ack) && n < BUDGET);
    a = ack;
    if (!(|ack)) check({tag, "_timeout"}, 32'(ack), 32'hFFFF_FFFF);
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_start && n < BUDGET);
    if (!tx_start) check({tag, "_timeout"}, 32'(tx_start), 32'd1);
  endtask

  initial begin
    logic [NUM_REQ-1:0] a;
    int j;
    reset    = 1'b0;
    req      = '0;
    req_data = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({gnt, ack, err, busy, tx_start, tx_data}), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // 1. Single request.
    set_data(0, 8'h01);
    push_exp(0, 8'h01);
    req = 4'b0001;
    wait_ack("single", a);
    req = '0;
    @(negedge clk);
    check("single_busy_after", 32'(busy), 32'd0);

    // 2. Round-robin order from reset (last_id = NUM_REQ-1).
    do_reset();
    set_data(0, 8'h11);
    set_data(1, 8'h22);
    set_data(2, 8'h33);
    set_data(3, 8'h44);
    push_exp(0, 8'h11);
    push_exp(1, 8'h22);
    push_exp(2, 8'h33);
    push_exp(3, 8'h44);
    req = 4'b1111;
    for (int k = 0; k < NUM_REQ; k++) begin
      wait_ack("rr", a);
      req = req & ~a;
    end

    // 3. Fairness resume: serve 1, then 2 must precede 0.
    push_exp(1, 8'h22);
    req = 4'b0010;
    wait_ack("fair_first", a);
    req = '0;
    push_exp(2, 8'h33);
    push_exp(0, 8'h11);
    req = 4'b0101;
    for (int k = 0; k < 2; k++) begin
      wait_ack("fair", a);
      req = req & ~a;
    end

    // 4. Watchdog: no tx_done, err expected TIMEOUT edges after leaving START.
    uart_en     = 1'b0;
    err_allowed = 1'b1;
    set_data(1, 8'h5a);
    req = 4'b0010;
    wait_start("wd");
    check("wd_gnt", 32'(gnt), 32'h2);
    j = 0;
    do begin
      @(negedge clk);
      j++;
    end while (!err && j < BUDGET);
    check("wd_latency", 32'(j), 32'(TIMEOUT + 1));
    check("wd_gnt_clear", 32'(gnt), 32'd0);
    check("wd_busy_clear", 32'(busy), 32'd0);
    check("wd_no_ack", 32'(ack), 32'd0);
    req = '0;
    @(negedge clk);
    check("wd_err_one_cycle", 32'(err), 32'd0);
    err_allowed = 1'b0;
    uart_en     = 1'b1;
    set_data(0, 8'h77);
    push_exp(0, 8'h77);
    req = 4'b0001;
    wait_ack("wd_next", a);
    req = '0;

    // 5. Reset mid-transfer.
    set_data(2, 8'hc3);
    push_exp(2, 8'hc3);
    req = 4'b0100;
    wait_start("rst_mid");
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    #1 check("rst_mid_outputs", 32'({gnt, ack, err, busy, tx_start, tx_data}), 32'd0);
    req = '0;
    void'(exp_q.pop_back());
    j = 0;
    while ((frame_cnt != 0 || tx_done) && j < BUDGET) begin
      @(negedge clk);
      j++;
    end
    check("rst_mid_frame_end", 32'(frame_cnt != 0 || tx_done), 32'd0);
    rx_q.delete();
    @(negedge clk);
    reset = 1'b1;
    set_data(0, 8'h01);
    push_exp(0, 8'h01);
    req = 4'b0001;
    wait_ack("rst_resume", a);
    req = '0;

    // 6. Request dropped one cycle after grant still completes.
    set_data(2, 8'haa);
    push_exp(2, 8'haa);
    req = 4'b0100;
    wait_start("drop");
    @(negedge clk);
    req = '0;
    wait_ack("drop", a);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("rx_queue_empty", 32'(rx_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
